// File: rtl/stream_prefetch_buffer.sv
// stream_prefetch_buffer
//   Next-line stream prefetcher that sits between the I-cache and the L2/PMEM arbiters.
//   A demand miss flushes the buffer, fetches the missing line through the L2 arbiter and
//   arms the stream. While idle, sequential lines after the miss are then prefetched
//   through the PMEM arbiter into a circular buffer of DEPTH entries. An I-cache read that
//   hits the buffer is answered combinationally in the same cycle.
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   pf_enable                       allow prefetches after a demand miss
//   i_read, i_address               I-cache request (held until i_resp)
//   i_rdata, i_resp                 line returned to the I-cache, one-cycle response pulse
//   l2_read, l2_address             demand read to the L2 arbiter (line aligned)
//   l2_rdata, l2_resp               demand completion
//   pmem_read, pmem_address         prefetch read to the PMEM arbiter (line aligned)
//   pmem_rdata, pmem_resp           prefetch completion
//   hit_count, miss_count, pf_count 32-bit saturating event counters (PF_STATS_EN only)
//
// Configuration macro
//   PF_STATS_EN : when defined, adds the three statistics counters and their output ports.
module stream_prefetch_buffer #(
  parameter int ADDR_WIDTH  = 16,
  parameter int OFFSET_BITS = 5,
  parameter int LINE_WIDTH  = 256,
  parameter int DEPTH       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pf_enable,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  output logic                  l2_read,
  output logic [ADDR_WIDTH-1:0] l2_address,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp,
  output logic                  pmem_read,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
`ifdef PF_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [31:0]           pf_count
`endif
);

  localparam int LINE_W = ADDR_WIDTH - OFFSET_BITS;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEMAND   = 2'd1,
    S_PREFETCH = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // Buffer control (reset) and buffer contents (not reset; guarded by r_valid)
  logic [DEPTH-1:0]    r_valid;
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;
  logic [LINE_W-1:0]   r_next_pf;
  logic [LINE_W-1:0]   r_miss_line;
  logic                r_armed;
  logic [LINE_W-1:0]   r_tag  [DEPTH];
  logic [LINE_WIDTH-1:0] r_data [DEPTH];

  logic [LINE_W-1:0]   w_req_line;
  logic                w_unused_offset;
  logic                w_hit;
  logic [PTR_W-1:0]    w_hit_idx;
  logic [PTR_W-1:0]    w_hit_off;
  logic [DEPTH-1:0]    w_drop_mask;
  logic [CNT_W-1:0]    w_drop;
  logic                w_full;
  logic                w_do_hit;
  logic                w_do_miss;
  logic                w_pf_done;

  assign w_req_line      = i_address[ADDR_WIDTH-1:OFFSET_BITS];
  assign w_unused_offset = ^i_address[OFFSET_BITS-1:0];
  assign w_full          = (r_count == CNT_W'(DEPTH));

  // Tag match plus the set of entries from head through the hit entry. Valid entries are
  // contiguous from head in stream order, so that set is everything whose distance from
  // head does not exceed the hit entry's distance.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_idx   = '0;
    w_drop_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_valid[k] && (r_tag[k] == w_req_line)) begin
        w_hit     = 1'b1;
        w_hit_idx = PTR_W'(k);
      end
    end
    w_hit_off = w_hit_idx - r_head;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PTR_W'(k) - r_head) <= w_hit_off) begin
        w_drop_mask[k] = 1'b1;
      end
    end
    w_drop = CNT_W'(w_hit_off) + CNT_W'(1);
  end

  assign w_do_hit  = (r_state == S_IDLE) && i_read && w_hit;
  assign w_do_miss = (r_state == S_IDLE) && i_read && !w_hit;
  assign w_pf_done = (r_state == S_PREFETCH) && pmem_resp;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_read) begin
          w_state_nxt = w_hit ? S_IDLE : S_DEMAND;
        end else if (pf_enable && !w_full && r_armed) begin
          w_state_nxt = S_PREFETCH;
        end
      end
      S_DEMAND:   if (l2_resp)   w_state_nxt = S_IDLE;
      S_PREFETCH: if (pmem_resp) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    i_resp       = 1'b0;
    i_rdata      = '0;
    l2_read      = 1'b0;
    l2_address   = '0;
    pmem_read    = 1'b0;
    pmem_address = '0;
    case (r_state)
      S_IDLE: begin
        if (i_read && w_hit) begin
          i_resp  = 1'b1;
          i_rdata = r_data[w_hit_idx];
        end
      end
      S_DEMAND: begin
        l2_read    = 1'b1;
        l2_address = {r_miss_line, {OFFSET_BITS{1'b0}}};
        if (l2_resp) begin
          i_resp  = 1'b1;
          i_rdata = l2_rdata;
        end
      end
      S_PREFETCH: begin
        pmem_read    = 1'b1;
        pmem_address = {r_next_pf, {OFFSET_BITS{1'b0}}};
      end
      default: ;
    endcase
  end

  // Buffer control: hits retire head..k, misses flush and re-arm, prefetches append at tail
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_next_pf   <= '0;
      r_miss_line <= '0;
      r_armed     <= 1'b0;
    end else if (w_do_hit) begin
      r_valid <= r_valid & ~w_drop_mask;
      r_head  <= w_hit_idx + PTR_W'(1);
      r_count <= r_count - w_drop;
    end else if (w_do_miss) begin
      r_valid     <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_miss_line <= w_req_line;
      r_next_pf   <= w_req_line + LINE_W'(1);
      r_armed     <= 1'b1;
    end else if (w_pf_done) begin
      r_valid[r_tail] <= 1'b1;
      r_tail          <= r_tail + PTR_W'(1);
      r_count         <= r_count + CNT_W'(1);
      r_next_pf       <= r_next_pf + LINE_W'(1);
    end
  end

  // Buffer contents
  always_ff @(posedge clk) begin
    if (w_pf_done) begin
      r_tag[r_tail]  <= r_next_pf;
      r_data[r_tail] <= pmem_rdata;
    end
  end

`ifdef PF_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;
  logic [31:0] r_pf_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_pf_count   <= '0;
    end else begin
      if (w_do_hit)  r_hit_count  <= sat_inc(r_hit_count);
      if (w_do_miss) r_miss_count <= sat_inc(r_miss_count);
      if (w_pf_done) r_pf_count   <= sat_inc(r_pf_count);
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
  assign pf_count   = r_pf_count;
`endif

endmodule

// File: tb/tb_stream_prefetch_buffer.sv
// Bench for stream_prefetch_buffer (default build, DEPTH=4, 16-bit addresses, 32-byte lines).
module tb_stream_prefetch_buffer;

  localparam int L2_LAT = 3;
  localparam int PM_LAT = 2;
  localparam int DEPTH  = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         pf_enable;
  logic         i_read;
  logic [15:0]  i_address;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         l2_read;
  logic [15:0]  l2_address;
  logic [255:0] l2_rdata;
  logic         l2_resp;
  logic         pmem_read;
  logic [15:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] l2_log[$];
  logic [15:0] pm_log[$];

  stream_prefetch_buffer #(
    .ADDR_WIDTH(16), .OFFSET_BITS(5), .LINE_WIDTH(256), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .pf_enable(pf_enable),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .l2_read(l2_read), .l2_address(l2_address), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .pmem_read(pmem_read), .pmem_address(pmem_address), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  // Line contents identify both source and address, so a misrouted line is visible.
  function automatic logic [255:0] mkdata(input logic src, input logic [15:0] a);
    logic [31:0] w;
    w = {(src ? 16'hC3C3 : 16'h1E1E), a};
    return {8{w}};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responders: each completes a held read after a fixed number of cycles.
  initial begin
    int l2c;
    int pmc;
    l2c = 0; pmc = 0;
    l2_resp = 1'b0; pmem_resp = 1'b0; l2_rdata = '0; pmem_rdata = '0;
    forever begin
      tick();
      l2_resp = 1'b0; pmem_resp = 1'b0; l2_rdata = '0; pmem_rdata = '0;
      if (reset) begin
        l2c = 0; pmc = 0;
      end else begin
        if (l2_read) begin
          l2c++;
          if (l2c == L2_LAT) begin
            l2_resp = 1'b1; l2_rdata = mkdata(1'b0, l2_address); l2c = 0;
          end
        end else l2c = 0;
        if (pmem_read) begin
          pmc++;
          if (pmc == PM_LAT) begin
            pmem_resp = 1'b1; pmem_rdata = mkdata(1'b1, pmem_address); pmc = 0;
          end
        end else pmc = 0;
      end
    end
  end

  // Behavioural model: a queue of buffered line numbers plus the one outstanding read.
  // Evaluated on the falling edge, where inputs are stable for the coming rising edge.
  initial begin
    logic [10:0] mq[$];
    logic        m_l2, m_pm, m_armed;
    logic [10:0] m_miss, m_next, line;
    logic        e_ir, e_l2r, e_pmr;
    logic [255:0] e_rd;
    logic [15:0] e_l2a, e_pma;
    int          idx;
    m_l2 = 0; m_pm = 0; m_armed = 0; m_miss = '0; m_next = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_l2 = 0; m_pm = 0; m_armed = 0; m_next = '0; mq.delete();
        chk("rst_i_resp", i_resp, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_l2_read", l2_read, 0);
        chk("rst_l2_address", l2_address, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_address", pmem_address, 0);
      end else begin
        e_ir = 0; e_rd = '0; e_l2r = 0; e_l2a = '0; e_pmr = 0; e_pma = '0;
        line = i_address[15:5];
        if (m_l2) begin
          e_l2r = 1; e_l2a = {m_miss, 5'b0};
          if (l2_resp) begin
            e_ir = 1; e_rd = mkdata(1'b0, {m_miss, 5'b0}); m_l2 = 0;
            l2_log.push_back(l2_address);
          end
        end else if (m_pm) begin
          e_pmr = 1; e_pma = {m_next, 5'b0};
          if (pmem_resp) begin
            pm_log.push_back(pmem_address);
            mq.push_back(m_next);
            m_next = m_next + 11'd1;
            m_pm = 0;
          end
        end else if (i_read) begin
          idx = -1;
          for (int j = 0; j < mq.size(); j++) if (mq[j] == line) idx = j;
          if (idx >= 0) begin
            e_ir = 1; e_rd = mkdata(1'b1, {line, 5'b0});
            repeat (idx + 1) void'(mq.pop_front());
          end else begin
            mq.delete();
            m_miss = line; m_next = line + 11'd1; m_armed = 1; m_l2 = 1;
          end
        end else if (pf_enable && mq.size() < DEPTH && m_armed) begin
          m_pm = 1;
        end
        chk("i_resp", i_resp, e_ir);
        if (e_ir) chk("i_rdata", i_rdata, e_rd);
        chk("l2_read", l2_read, e_l2r);
        chk("l2_address", l2_address, e_l2a);
        chk("pmem_read", pmem_read, e_pmr);
        chk("pmem_address", pmem_address, e_pma);
        if (l2_read && pmem_read) chk("one_outstanding", 1, 0);
      end
    end
  end

  // Issue a read, wait (bounded) for its response, then drop the request.
  task automatic do_read(input logic [15:0] a, output logic [255:0] rd, output int n);
    i_read = 1'b1; i_address = a; n = 0; rd = '0;
    forever begin
      @(negedge clk);
      if (i_resp) begin
        rd = i_rdata;
        break;
      end
      n++;
      if (n > 200) begin
        n_checks++; n_errors++;
        $display("FAIL read_timeout: got no i_resp expected i_resp for %h", a);
        break;
      end
    end
    tick();
    i_read = 1'b0;
  endtask

  initial begin
    logic [255:0] rd;
    int n;
    reset = 1'b1; pf_enable = 1'b0; i_read = 1'b0; i_address = '0;
    tick(); tick();
    chk("reset_l2_read", l2_read, 0);
    chk("reset_pmem_read", pmem_read, 0);
    chk("reset_i_resp", i_resp, 0);
    reset = 1'b0;
    pf_enable = 1'b1;
    tick();

    // 1: demand miss at 0x0040, then four prefetches until full
    do_read(16'h0040, rd, n);
    chk("t1_miss_data", rd, mkdata(1'b0, 16'h0040));
    chk("t1_miss_wait", n, L2_LAT);
    chk("t1_l2_addr_n", l2_log.size(), 1);
    chk("t1_l2_addr", l2_log[0], 16'h0040);
    repeat (30) tick();
    chk("t1_pf_n", pm_log.size(), 4);
    if (pm_log.size() == 4) begin
      chk("t1_pf0", pm_log[0], 16'h0060);
      chk("t1_pf1", pm_log[1], 16'h0080);
      chk("t1_pf2", pm_log[2], 16'h00A0);
      chk("t1_pf3", pm_log[3], 16'h00C0);
    end
    chk("t1_full_idle", pmem_read, 0);

    // 2: hit in the middle of the buffer, two entries retire, two refills
    l2_log.delete(); pm_log.delete();
    do_read(16'h0084, rd, n);
    chk("t2_hit_wait", n, 0);
    chk("t2_hit_data", rd, mkdata(1'b1, 16'h0080));
    repeat (30) tick();
    chk("t2_no_l2", l2_log.size(), 0);
    chk("t2_pf_n", pm_log.size(), 2);
    if (pm_log.size() == 2) begin
      chk("t2_pf0", pm_log[0], 16'h00E0);
      chk("t2_pf1", pm_log[1], 16'h0100);
    end

    // 3: a miss raised while a prefetch is in flight waits for it, then flushes
    pm_log.delete();
    do_read(16'h00A4, rd, n);
    chk("t3_hit_data", rd, mkdata(1'b1, 16'h00A0));
    tick();
    chk("t3_pf_active", pmem_read, 1);
    chk("t3_pf_addr", pmem_address, 16'h0120);
    do_read(16'h1000, rd, n);
    chk("t3_miss_data", rd, mkdata(1'b0, 16'h1000));
    chk("t3_pf_done", pm_log.size(), 1);
    chk("t3_l2_n", l2_log.size(), 1);
    if (l2_log.size() == 1) chk("t3_l2_addr", l2_log[0], 16'h1000);
    repeat (30) tick();
    do_read(16'h1044, rd, n);
    chk("t3_stream_hit_wait", n, 0);
    chk("t3_stream_hit_data", rd, mkdata(1'b1, 16'h1040));
    l2_log.delete();
    do_read(16'h0124, rd, n);
    chk("t3_flushed_miss", l2_log.size(), 1);
    chk("t3_flushed_data", rd, mkdata(1'b0, 16'h0120));
    repeat (30) tick();

    // 4: wrap-around of the line number
    pm_log.delete();
    do_read(16'hFFE0, rd, n);
    repeat (30) tick();
    chk("t4_pf_n", pm_log.size(), 4);
    if (pm_log.size() >= 2) begin
      chk("t4_pf0", pm_log[0], 16'h0000);
      chk("t4_pf1", pm_log[1], 16'h0020);
    end

    // 5: prefetch disabled
    pf_enable = 1'b0;
    pm_log.delete();
    do_read(16'h0200, rd, n);
    chk("t5_miss_data", rd, mkdata(1'b0, 16'h0200));
    repeat (20) tick();
    chk("t5_no_pf", pm_log.size(), 0);

    // 6: reset in the middle of a PMEM read
    pf_enable = 1'b1;
    do_read(16'h0300, rd, n);
    for (int k = 0; k < 20 && !pmem_read; k++) tick();
    chk("t6_pf_active", pmem_read, 1);
    reset = 1'b1;
    #1;
    chk("t6_reset_drop", pmem_read, 0);
    tick();
    reset = 1'b0;
    l2_log.delete();
    do_read(16'h0064, rd, n);
    chk("t6_after_reset_miss", l2_log.size(), 1);
    chk("t6_after_reset_data", rd, mkdata(1'b0, 16'h0060));
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
